// File: rtl/uart_bus_slave.sv
// uart_bus_slave: memory-mapped 8N1 UART slave on the 16-bit CPU bus (TX FIFO, RX buffer, IRQ).
// Optional build macro UART_RX_FIFO_EN: RX buffer becomes a 2^RX_AW FIFO instead of a holding register.
module uart_bus_slave #(
    parameter int unsigned TX_AW   = 4,
    parameter int unsigned RX_AW   = 4,
    parameter logic [15:0] DIV_RST = 16'd433
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] slave_write,
    output logic [15:0] slave_read,
    input  logic [7:0]  slave_addr,
    input  logic [1:0]  slave_ds,
    input  logic        slave_rw,
    output logic        slave_ack,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        irq
);
    localparam int unsigned TX_DEPTH = 1 << TX_AW;
    localparam int unsigned TX_CW    = TX_AW + 1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        access, wr_en, rd_en;
    logic [1:0]  reg_sel;
    logic [15:0] div_reg;
    logic [1:0]  ctrl;
    logic        ferr, ovr, txovf;
    logic [7:0]  status;
    logic [15:0] rd_data;
    logic        unused_addr;

    assign reg_sel     = slave_addr[2:1];
    assign access      = (slave_ds != 2'b00) && !slave_ack;
    assign wr_en       = access && !slave_rw;
    assign rd_en       = access && slave_rw;
    assign unused_addr = ^{slave_addr[7:3], slave_addr[0]};

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wptr, tx_rptr;
    logic [TX_CW-1:0] tx_count;
    logic             tx_empty, tx_full, tx_push_req, tx_push, tx_pop;

    assign tx_empty    = tx_count == '0;
    assign tx_full     = tx_count == TX_CW'(TX_DEPTH);
    assign tx_push_req = wr_en && (reg_sel == REG_DATA) && slave_ds[0];
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= slave_write[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CW'(1);
                2'b01:   tx_count <= tx_count - TX_CW'(1);
                default: ;
            endcase
        end
    end

    // ---------------- TX serialiser ----------------
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_div;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bit;
    logic        tx_tick, tx_busy;

    assign tx_tick = tx_cnt == 16'd0;
    assign tx_busy = tx_state != TX_IDLE;

    always_ff @(posedge clk) begin
        if (!reset_n) tx_state <= TX_IDLE;
        else          tx_state <= tx_state_n;
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TX_START;
                end
            end
            TX_START: if (tx_tick) tx_state_n = TX_DATA;
            TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_state_n = TX_STOP;
            TX_STOP: begin
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Divisor is latched at frame start so mid-frame DIV writes cannot distort a frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uart_txd <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
        end else if (tx_pop) begin
            uart_txd <= 1'b0;
            tx_cnt   <= div_reg;
            tx_div   <= div_reg;
            tx_shift <= tx_mem[tx_rptr];
            tx_bit   <= '0;
        end else if (tx_busy) begin
            if (!tx_tick) begin
                tx_cnt <= tx_cnt - 16'd1;
            end else begin
                tx_cnt <= tx_div;
                case (tx_state)
                    TX_START: uart_txd <= tx_shift[0];
                    TX_DATA: begin
                        if (tx_bit == 3'd7) begin
                            uart_txd <= 1'b1;
                        end else begin
                            uart_txd <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                    default: uart_txd <= 1'b1;
                endcase
            end
        end
    end

    // ---------------- RX deserialiser ----------------
    logic        rxd_meta, rxd_sync, rxd_prev, rx_fall;
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_div;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_bit;
    logic        rx_tick, rx_store, rx_ferr_set;

    assign rx_fall = rxd_prev && !rxd_sync;
    assign rx_tick = rx_cnt == 16'd0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) rx_state <= RX_IDLE;
        else          rx_state <= rx_state_n;
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_store    = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
            RX_START: if (rx_tick) rx_state_n = rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_state_n = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_n  = RX_IDLE;
                    rx_store    = rxd_sync;
                    rx_ferr_set = !rxd_sync;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // First wait is shortened by the synchroniser/edge-detect latency so samples land mid-bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else if (rx_state == RX_IDLE) begin
            if (rx_fall) begin
                rx_cnt <= (div_reg == 16'd0) ? 16'd0 : ((div_reg - 16'd1) >> 1);
                rx_div <= div_reg;
                rx_bit <= '0;
            end
        end else if (!rx_tick) begin
            rx_cnt <= rx_cnt - 16'd1;
        end else begin
            rx_cnt <= rx_div;
            if (rx_state == RX_DATA) begin
                rx_shift <= {rxd_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    // ---------------- RX buffer ----------------
    logic       rx_ne, rx_full, rx_pop, rx_accept;
    logic [7:0] rx_head;

    assign rx_pop    = rd_en && (reg_sel == REG_DATA) && slave_ds[0] && rx_ne;
    assign rx_accept = rx_store && (!rx_full || rx_pop);

`ifdef UART_RX_FIFO_EN
    localparam int unsigned RX_DEPTH = 1 << RX_AW;
    localparam int unsigned RX_CW    = RX_AW + 1;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wptr, rx_rptr;
    logic [RX_CW-1:0] rx_count;

    assign rx_ne   = rx_count != '0;
    assign rx_full = rx_count == RX_CW'(RX_DEPTH);
    assign rx_head = rx_mem[rx_rptr];

    always_ff @(posedge clk) begin
        if (rx_accept) rx_mem[rx_wptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_accept) rx_wptr <= rx_wptr + RX_AW'(1);
            if (rx_pop)    rx_rptr <= rx_rptr + RX_AW'(1);
            case ({rx_accept, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CW'(1);
                2'b01:   rx_count <= rx_count - RX_CW'(1);
                default: ;
            endcase
        end
    end
`else
    localparam int unsigned RX_AW_UNUSED = RX_AW;

    logic [7:0] rx_hold;
    logic       rx_valid;

    assign rx_ne   = rx_valid;
    assign rx_full = rx_valid;
    assign rx_head = rx_hold;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_hold  <= '0;
            rx_valid <= 1'b0;
        end else if (rx_accept) begin
            rx_hold  <= rx_shift;
            rx_valid <= 1'b1;
        end else if (rx_pop) begin
            rx_valid <= 1'b0;
        end
    end
`endif

    // ---------------- Registers and bus ----------------
    logic stat_rd;

    assign stat_rd = rd_en && (reg_sel == REG_STATUS);
    assign status  = {ferr, ovr, txovf, tx_busy, tx_full, tx_empty, rx_full, rx_ne};

    // Sticky flags: a new event in the same cycle as a STATUS read survives the clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_reg <= DIV_RST;
            ctrl    <= '0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
            txovf   <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == REG_DIV)) begin
                if (slave_ds[1]) div_reg[15:8] <= slave_write[15:8];
                if (slave_ds[0]) div_reg[7:0]  <= slave_write[7:0];
            end
            if (wr_en && (reg_sel == REG_CTRL) && slave_ds[0]) ctrl <= slave_write[1:0];
            ferr  <= (ferr  && !stat_rd) || rx_ferr_set;
            ovr   <= (ovr   && !stat_rd) || (rx_store && !rx_accept);
            txovf <= (txovf && !stat_rd) || (tx_push_req && !tx_push);
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        case (reg_sel)
            REG_DATA:   rd_data = {8'h00, rx_ne ? rx_head : 8'h00};
            REG_STATUS: rd_data = {8'h00, status};
            REG_DIV:    rd_data = div_reg;
            REG_CTRL:   rd_data = {14'h0000, ctrl};
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slave_ack  <= 1'b0;
            slave_read <= '0;
            irq        <= 1'b0;
        end else begin
            slave_ack <= slave_ds != 2'b00;
            if (access) slave_read <= slave_rw ? rd_data : 16'h0000;
            irq <= (rx_ne && ctrl[0]) || (tx_empty && ctrl[1]);
        end
    end

endmodule

// File: tb/tb_uart_bus_slave.sv
// Self-checking bench for uart_bus_slave: directed sequence with randomized bytes/divisors
// checked against a frame-level model of the 8N1 link and bus registers.
module tb_uart_bus_slave;
    localparam logic [1:0] R_DATA   = 2'd0;
    localparam logic [1:0] R_STATUS = 2'd1;
    localparam logic [1:0] R_DIV    = 2'd2;
    localparam logic [1:0] R_CTRL   = 2'd3;

`ifdef UART_RX_FIFO_EN
    localparam int RX_CAP = 16;
`else
    localparam int RX_CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] slave_write, slave_read;
    logic [7:0]  slave_addr;
    logic [1:0]  slave_ds;
    logic        slave_rw, slave_ack, uart_txd, uart_rxd, irq;
    logic        loop_en, rxd_drv;
    int          checks = 0;
    int          errors = 0;

    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    always #5 clk = ~clk;

    uart_bus_slave dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .slave_write (slave_write),
        .slave_read  (slave_read),
        .slave_addr  (slave_addr),
        .slave_ds    (slave_ds),
        .slave_rw    (slave_rw),
        .slave_ack   (slave_ack),
        .uart_txd    (uart_txd),
        .uart_rxd    (uart_rxd),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access; the slave must ack exactly one cycle after the strobe is presented.
    task automatic bus(input logic rw, input logic [1:0] idx, input logic [15:0] wdata,
                       input logic [1:0] ds, output logic [15:0] rdata);
        slave_rw    = rw;
        slave_addr  = {5'($urandom), idx, 1'($urandom)};
        slave_write = wdata;
        slave_ds    = ds;
        @(posedge clk); #1;
        chk("ack_rise", 16'(slave_ack), 16'd1);
        rdata    = slave_read;
        slave_ds = 2'b00;
        slave_rw = 1'b1;
        @(posedge clk); #1;
        chk("ack_fall", 16'(slave_ack), 16'd0);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [15:0] wdata, input logic [1:0] ds);
        logic [15:0] dummy;
        bus(1'b0, idx, wdata, ds, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] idx, input logic [15:0] exp);
        logic [15:0] r;
        bus(1'b1, idx, 16'h0000, 2'b11, r);
        chk(tag, r, exp);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        slave_ds = 2'b00;
        slave_rw = 1'b1;
        loop_en  = 1'b0;
        rxd_drv  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Expected 8N1 waveform: start 0, data LSB first, stop 1, each bit d+1 cycles.
    task automatic expect_frame(input logic [7:0] b, input int d);
        logic [9:0] frame;
        int n;
        frame = {1'b1, b, 1'b0};
        n = 0;
        while (uart_txd === 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tx_start_seen", 16'(uart_txd), 16'd0);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c <= d; c++) begin
                chk("tx_bit", 16'(uart_txd), 16'(frame[i]));
                @(posedge clk); #1;
            end
        end
        chk("tx_idle_after", 16'(uart_txd), 16'd1);
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop, input int d);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = frame[i];
            repeat (d + 1) @(posedge clk);
            #1;
        end
        rxd_drv = 1'b1;
        repeat (2 * (d + 1) + 4) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0]  b;
        logic [7:0]  q[$];
        logic [15:0] st_one;
        int          d;

        st_one      = 16'h0005 | ((RX_CAP == 1) ? 16'h0002 : 16'h0000);
        slave_write = 16'h0000;
        slave_addr  = 8'h00;

        // Reset state
        do_reset();
        chk("rst_txd", 16'(uart_txd), 16'd1);
        chk("rst_ack", 16'(slave_ack), 16'd0);
        chk("rst_irq", 16'(irq), 16'd0);
        chk("rst_read", slave_read, 16'h0000);
        rd_chk("rst_status", R_STATUS, 16'h0004);
        rd_chk("rst_div", R_DIV, 16'd433);
        rd_chk("rst_ctrl", R_CTRL, 16'h0000);
        rd_chk("rst_data_empty", R_DATA, 16'h0000);

        // Register access: byte-lane DIV write, CTRL masking, TX-empty interrupt
        wr(R_DIV, 16'hAB55, 2'b10);
        rd_chk("div_upper_only", R_DIV, 16'hABB1);
        wr(R_CTRL, 16'hFFFF, 2'b11);
        rd_chk("ctrl_mask", R_CTRL, 16'h0003);
        chk("irq_txie", 16'(irq), 16'd1);
        wr(R_CTRL, 16'h0000, 2'b01);
        chk("irq_off", 16'(irq), 16'd0);
        wr(R_STATUS, 16'hFFFF, 2'b11);
        rd_chk("status_wr_ignored", R_STATUS, 16'h0004);

        // TX waveform at DIV=3
        wr(R_DIV, 16'd3, 2'b11);
        wr(R_DATA, 16'h0055, 2'b01);
        expect_frame(8'h55, 3);
        rd_chk("tx_done_status", R_STATUS, 16'h0004);

        // Held strobe pushes a single byte (slow divisor keeps it in flight)
        do_reset();
        wr(R_DIV, 16'hFFFF, 2'b11);
        slave_rw    = 1'b0;
        slave_addr  = 8'h00;
        slave_write = 16'h00C3;
        slave_ds    = 2'b01;
        chk("hs_pre", 16'(slave_ack), 16'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hs_hold", 16'(slave_ack), 16'd1);
        end
        slave_ds = 2'b00;
        slave_rw = 1'b1;
        @(posedge clk); #1;
        chk("hs_drop", 16'(slave_ack), 16'd0);
        rd_chk("hs_one_push", R_STATUS, 16'h0014);

        // TX overflow: one byte in the shifter plus 16 in the FIFO, the next is dropped
        do_reset();
        wr(R_DIV, 16'hFFFF, 2'b11);
        for (int i = 0; i < 17; i++) wr(R_DATA, 16'($urandom_range(255, 0)), 2'b01);
        rd_chk("txfifo_full", R_STATUS, 16'h0018);
        wr(R_DATA, 16'h00EE, 2'b01);
        rd_chk("txovf_set", R_STATUS, 16'h0038);
        rd_chk("txovf_cleared", R_STATUS, 16'h0018);

        // Loopback: fixed 0xA3 at DIV=3 then random bytes and divisors
        do_reset();
        loop_en = 1'b1;
        wr(R_CTRL, 16'h0001, 2'b01);
        for (int k = 0; k < 9; k++) begin
            d = (k == 0) ? 3 : int'($urandom_range(6, 1));
            b = (k == 0) ? 8'hA3 : 8'($urandom);
            wr(R_DIV, 16'(d), 2'b11);
            wr(R_DATA, {8'h00, b}, 2'b01);
            repeat (10 * (d + 1) + 16) @(posedge clk);
            #1;
            chk("lb_irq_on", 16'(irq), 16'd1);
            rd_chk("lb_status_rxne", R_STATUS, st_one);
            rd_chk("lb_data", R_DATA, {8'h00, b});
            chk("lb_irq_off", 16'(irq), 16'd0);
            rd_chk("lb_status_empty", R_STATUS, 16'h0004);
        end

        // Framing error, glitch rejection and a clean manual frame
        do_reset();
        wr(R_DIV, 16'd3, 2'b11);
        send_serial(8'h5A, 1'b0, 3);
        rd_chk("ferr_set", R_STATUS, 16'h0084);
        rd_chk("ferr_cleared", R_STATUS, 16'h0004);
        rxd_drv = 1'b0;
        @(posedge clk); #1;
        rxd_drv = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rd_chk("glitch_ignored", R_STATUS, 16'h0004);
        b = 8'($urandom);
        send_serial(b, 1'b1, 3);
        rd_chk("rx_status", R_STATUS, st_one);
        rd_chk("rx_data", R_DATA, {8'h00, b});

        // Overrun: 17 unread frames, buffer keeps the first RX_CAP bytes
        q.delete();
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom);
            if (q.size() < RX_CAP) q.push_back(b);
            send_serial(b, 1'b1, 3);
        end
        rd_chk("ovr_status", R_STATUS, 16'h0047);
        while (q.size() > 0) begin
            b = q.pop_front();
            rd_chk("ovr_data", R_DATA, {8'h00, b});
        end
        rd_chk("ovr_cleared", R_STATUS, 16'h0004);
        rd_chk("empty_read_zero", R_DATA, 16'h0000);
        rd_chk("empty_no_pop", R_STATUS, 16'h0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
